// File: rtl/bomb_pkg.sv
// Shared slot state encoding and blast-cross geometry for the bomb pool.
package bomb_pkg;

    typedef enum logic [1:0] {
        FREE      = 2'b00,
        ARMED     = 2'b01,
        EXPLODING = 2'b10
    } slot_state_t;

    // Callers pass zero-extended tile coordinates, so signed int differences
    // give the same result as TILE_W+1-bit signed math, with no wrap at edges.
    function automatic logic in_blast(input int x, input int y, input int bx,
                                      input int by, input int radius);
        int dx, dy;
        dx = x - bx;
        dy = y - by;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return ((dx == 0) && (dy <= radius)) || ((dy == 0) && (dx <= radius));
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FREE -> ARMED -> EXPLODING -> FREE, fuse and blast counted in frame ticks.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int TILE_W       = 5,
    parameter int CNT_W        = 7,
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              alloc,
    input  logic [TILE_W-1:0] tile_x,
    input  logic [TILE_W-1:0] tile_y,
    input  logic              frame_tick,
    input  logic              chain_hit,
    output slot_state_t       state,
    output logic [TILE_W-1:0] x,
    output logic [TILE_W-1:0] y
);

    slot_state_t      state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    // Allocation wins over the tick, so a slot armed on a tick cycle starts its full fuse.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (alloc) begin
            state_d = ARMED;
            cnt_d   = CNT_W'(FUSE_FRAMES);
        end else if (frame_tick) begin
            case (state)
                ARMED: begin
                    if (chain_hit || cnt == CNT_W'(1)) begin
                        state_d = EXPLODING;
                        cnt_d   = CNT_W'(BLAST_FRAMES);
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                EXPLODING: begin
                    if (cnt == CNT_W'(1)) begin
                        state_d = FREE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= FREE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (alloc) begin
                x <= tile_x;
                y <= tile_y;
            end
        end
    end

endmodule

// File: rtl/bomb_pool.sv
// Pool of bomb slots with drop arbitration and per-player blast probes.
// Optional BOMB_CHAIN_REACT_EN: blasts detonate armed bombs in their cross, one hop per tick.
module bomb_pool
    import bomb_pkg::*;
#(
    parameter int N_PLAYERS        = 2,
    parameter int SLOTS_PER_PLAYER = 2,
    parameter int GRID_W           = 20,
    parameter int GRID_H           = 15,
    parameter int TILE_W           = 5,
    parameter int FUSE_FRAMES      = 120,
    parameter int BLAST_FRAMES     = 30,
    parameter int RADIUS           = 2
) (
    input  logic                                                Clk,
    input  logic                                                Reset,
    input  logic                                                frame_tick,
    input  logic [N_PLAYERS-1:0]                                drop_req,
    input  logic [N_PLAYERS-1:0][TILE_W-1:0]                    drop_x,
    input  logic [N_PLAYERS-1:0][TILE_W-1:0]                    drop_y,
    output logic [N_PLAYERS-1:0]                                drop_ack,
    output logic [N_PLAYERS-1:0]                                drop_nack,
    input  logic [N_PLAYERS-1:0][TILE_W-1:0]                    probe_x,
    input  logic [N_PLAYERS-1:0][TILE_W-1:0]                    probe_y,
    output logic [N_PLAYERS-1:0]                                probe_hit,
    output logic [N_PLAYERS*SLOTS_PER_PLAYER-1:0][1:0]          slot_state,
    output logic [N_PLAYERS*SLOTS_PER_PLAYER-1:0][TILE_W-1:0]   slot_x,
    output logic [N_PLAYERS*SLOTS_PER_PLAYER-1:0][TILE_W-1:0]   slot_y,
    output logic [N_PLAYERS-1:0][$clog2(SLOTS_PER_PLAYER+1)-1:0] bombs_used
);

    localparam int NS         = N_PLAYERS * SLOTS_PER_PLAYER;
    localparam int MAX_FRAMES = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    slot_state_t          st [NS];
    logic [NS-1:0]        alloc, chain_hit;
    logic [N_PLAYERS-1:0] grant, hit_d;

    for (genvar i = 0; i < NS; i++) begin : g_slot
        bomb_slot #(
            .TILE_W      (TILE_W),
            .CNT_W       (CNT_W),
            .FUSE_FRAMES (FUSE_FRAMES),
            .BLAST_FRAMES(BLAST_FRAMES)
        ) u_slot (
            .Clk       (Clk),
            .Reset     (Reset),
            .alloc     (alloc[i]),
            .tile_x    (drop_x[i/SLOTS_PER_PLAYER]),
            .tile_y    (drop_y[i/SLOTS_PER_PLAYER]),
            .frame_tick(frame_tick),
            .chain_hit (chain_hit[i]),
            .state     (st[i]),
            .x         (slot_x[i]),
            .y         (slot_y[i])
        );
        assign slot_state[i] = st[i];
    end

`ifdef BOMB_CHAIN_REACT_EN
    always_comb begin
        chain_hit = '0;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++)
                if (st[j] == EXPLODING &&
                    in_blast(int'(slot_x[i]), int'(slot_y[i]), int'(slot_x[j]), int'(slot_y[j]), RADIUS))
                    chain_hit[i] = 1'b1;
    end
`else
    assign chain_hit = '0;
`endif

    // A lower-index player granted the same tile this cycle blocks the higher ones.
    always_comb begin
        logic busy, has_free, in_grid;
        int   free_s;
        grant    = '0;
        alloc    = '0;
        busy     = 1'b0;
        has_free = 1'b0;
        in_grid  = 1'b0;
        free_s   = 0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            busy     = 1'b0;
            has_free = 1'b0;
            free_s   = 0;
            in_grid  = ({1'b0, drop_x[p]} < (TILE_W+1)'(GRID_W)) &&
                       ({1'b0, drop_y[p]} < (TILE_W+1)'(GRID_H));
            for (int i = 0; i < NS; i++)
                if (st[i] != FREE && slot_x[i] == drop_x[p] && slot_y[i] == drop_y[p])
                    busy = 1'b1;
            for (int q = 0; q < p; q++)
                if (grant[q] && drop_x[q] == drop_x[p] && drop_y[q] == drop_y[p])
                    busy = 1'b1;
            for (int s = SLOTS_PER_PLAYER - 1; s >= 0; s--)
                if (st[p*SLOTS_PER_PLAYER + s] == FREE) begin
                    has_free = 1'b1;
                    free_s   = s;
                end
            grant[p] = drop_req[p] && in_grid && has_free && !busy;
            if (grant[p])
                alloc[p*SLOTS_PER_PLAYER + free_s] = 1'b1;
        end
    end

    always_comb begin
        hit_d = '0;
        for (int p = 0; p < N_PLAYERS; p++)
            for (int i = 0; i < NS; i++)
                if (st[i] == EXPLODING &&
                    in_blast(int'(probe_x[p]), int'(probe_y[p]), int'(slot_x[i]), int'(slot_y[i]), RADIUS))
                    hit_d[p] = 1'b1;
    end

    always_comb begin
        bombs_used = '0;
        for (int p = 0; p < N_PLAYERS; p++)
            for (int s = 0; s < SLOTS_PER_PLAYER; s++)
                if (st[p*SLOTS_PER_PLAYER + s] != FREE)
                    bombs_used[p] = bombs_used[p] + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            drop_ack  <= '0;
            drop_nack <= '0;
            probe_hit <= '0;
        end else begin
            drop_ack  <= grant;
            drop_nack <= drop_req & ~grant;
            probe_hit <= hit_d;
        end
    end

endmodule

// File: doc/bomb_pool.md
# bomb_pool

Parametrised bomb manager replacing the fixed two-player, one-bomb-per-player bomb and bomb-state logic. It holds a pool of bomb slots for `N_PLAYERS` players with `SLOTS_PER_PLAYER` bombs each, and runs each slot's fuse and blast timers on frame ticks. It answers per-player "is this tile in a blast" probes, which feed player death detection and the colour mapper.

## Interface
- `N_PLAYERS`, 2, number of players / request and probe channels
- `SLOTS_PER_PLAYER`, 2, simultaneous bombs per player
- `GRID_W`, 20, tile columns; `GRID_H`, 15, tile rows
- `TILE_W`, 5, tile coordinate width (must hold max(`GRID_W`, `GRID_H`) - 1)
- `FUSE_FRAMES`, 120, frame ticks from drop to explosion (must be >= 1)
- `BLAST_FRAMES`, 30, frame ticks a blast stays active (must be >= 1)
- `RADIUS`, 2, blast arm length in tiles
- `Clk`  in  1  system clock; every flop is clocked here
- `Reset`  in  1  asynchronous, active-high
- `frame_tick`  in  1  one-`Clk` pulse per video frame
- `drop_req`  in  N_PLAYERS  one-cycle drop request per player
- `drop_x`, `drop_y`  in  N_PLAYERS*TILE_W  requested tile, sampled with `drop_req`
- `drop_ack`, `drop_nack`  out  N_PLAYERS  one-cycle response pulses
- `probe_x`, `probe_y`  in  N_PLAYERS*TILE_W  tile to test, one probe per player
- `probe_hit`  out  N_PLAYERS  probed tile lies in an active blast
- `slot_state`  out  2*N_PLAYERS*SLOTS_PER_PLAYER  per-slot state, for the colour mapper
- `slot_x`, `slot_y`  out  TILE_W*N_PLAYERS*SLOTS_PER_PLAYER  per-slot tile
- `bombs_used`  out  N_PLAYERS*$clog2(SLOTS_PER_PLAYER+1)  slots not in FREE, per player

## Operation
- Slot `s` of player `p` has flat index `p*SLOTS_PER_PLAYER+s`.
- Slot states: FREE -> ARMED -> EXPLODING -> FREE.
- **Drop.** Player `p` pulses `drop_req`. One of `drop_ack` or `drop_nack` pulses exactly one cycle later.
- A drop is refused (nack) when any of these holds:
  - `drop_x >= GRID_W` or `drop_y >= GRID_H`;
  - the player has no FREE slot;
  - any slot of any player at that tile is in ARMED or EXPLODING.
- **Same-tile, same-cycle requests.** The lowest player index wins; the others are nacked.
- **Ack.** The player's lowest-index FREE slot goes to ARMED, stores the tile, and sets `fuse = FUSE_FRAMES`.
- **Fuse.** On a `frame_tick` cycle, each ARMED slot decrements `fuse`. When the value before the decrement is 1, the slot goes to EXPLODING with `blast = BLAST_FRAMES`.
- **Blast.** Each EXPLODING slot decrements `blast` on `frame_tick`. When the value before the decrement is 1, the slot goes to FREE.
- **Drop on a tick cycle.** A slot allocated in a `frame_tick` cycle is not decremented in that cycle.
- **Same-cycle release.** A slot released in cycle `t` can be allocated by a request in cycle `t+1`. A request in cycle `t` sees the slot as busy.
- **Blast cross.** Tile (x, y) is hit when some EXPLODING slot at (bx, by) satisfies either:
  - `x == bx` and `|y - by| <= RADIUS`, or
  - `y == by` and `|x - bx| <= RADIUS`.
- Blast arms clip naturally at the grid edges. Walls are not modelled; wall occlusion is the colour mapper's job.
- **Arithmetic.** Differences are computed at `TILE_W+1` bits, signed. Counters are `$clog2(max(FUSE_FRAMES, BLAST_FRAMES)+1)` bits wide.

## Timing
- Reset values: all slots FREE, counters 0, `slot_x`/`slot_y` 0, `drop_ack`/`drop_nack`/`probe_hit` 0, `bombs_used` 0.
- Asserting `Reset` mid-operation clears every bomb immediately, with no explosion.
- Drop response latency: 1 cycle. A state change is visible on `slot_state` in the same cycle as the ack.
- `probe_hit` is registered: it reflects the probe sampled in cycle `t` against slot state at cycle `t`, and appears in `t+1`.
- With default parameters, a bomb explodes exactly `FUSE_FRAMES` ticks after its ack.

## Configuration
- `BOMB_CHAIN_REACT_EN` defined: on a `frame_tick`, any ARMED slot whose tile is in the blast cross of a slot that was EXPLODING before the tick goes to EXPLODING with `blast = BLAST_FRAMES`.
  - Propagation is one hop per tick.
- Not defined: ARMED slots ignore blasts and follow their own fuse only.

## Structure
- Package `bomb_pkg` holds:
  - `slot_state_t` enum: FREE = 2'b00, ARMED = 2'b01, EXPLODING = 2'b10;
  - function `in_blast(x, y, bx, by, radius)`.
- Sub-module `bomb_slot` holds one slot's state, tile and counters, with inputs `alloc`, tile, `frame_tick`, `chain_hit`.
- `bomb_pool` instantiates `N_PLAYERS*SLOTS_PER_PLAYER` `bomb_slot` instances and adds allocation, arbitration and the probe logic.

## Test plan
Bench parameters: `FUSE_FRAMES=3`, `BLAST_FRAMES=2`, `RADIUS=2`.
- Player 0 drops at (4,4) -> ack next cycle; slot 0 ARMED. After 3 ticks it is EXPLODING; after 2 more ticks it is FREE.
- Player 0 drops a third bomb while two are ARMED -> nack; `bombs_used[0] = 2`.
- Players 0 and 1 drop at (7,3) in the same cycle -> ack for player 0, nack for player 1. Then player 1 drops at (7,3) while that bomb is ARMED -> nack.
- Bomb at (4,4) EXPLODING; probe (6,4) -> hit; (7,4) -> no hit; (5,5) -> no hit; (4,2) -> hit. At (0,0), probe (0,2) -> hit, with no wrap.
- Drop at (20,0) -> nack. `Reset` asserted while two bombs are ARMED -> all outputs zero immediately.
- `BOMB_CHAIN_REACT_EN`: bombs at (4,4) and (6,4), the second dropped 2 ticks later. The first explodes at tick 3; the second is EXPLODING at tick 4, not at tick 5. With the macro undefined, the second explodes at tick 5.
